fifo_stream_reader: RTL and testbench

Read-side adapter for the team's FIFOs. It drains a FIFO read port, which uses a pop/empty handshake and returns data a fixed `READ_LATENCY` cycles after each pop, and presents the data as a valid/ready stream. It sits in the read clock domain, between a FIFO's `pop_i`/`empty_o`/`rd_data_o` and a downstream AXI-Stream-style consumer. It hides the RAM read latency and sustains one word per cycle under continuous `ready`.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/stream_skid_buf.sv | 68 ++++++
 rtl/fifo_stream_reader.sv | 75 +++++++
 tb/tb_fifo_stream_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : constants and helpers shared by the FIFO read-side blocks
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int MAX_READ_LATENCY = 4;

  // Skid depth needed to keep one word per cycle flowing past the RAM latency
  function automatic int skid_depth(input int read_latency);
    return read_latency + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_skid_buf : circular word buffer with a valid/ready output stream
// Rev 1.0
// ---------------------------------------------------------------------------
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [OCC_W-1:0]      occ;
  logic                  rd_fire;

  // Indices wrap explicitly so DEPTH need not be a power of two
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign m_tvalid_o = (occ != '0);
  assign rd_fire    = m_tvalid_o & m_tready_i;
  assign m_tdata_o  = m_tvalid_o ? mem[rd_idx] : '0;
  assign occ_o      = occ;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (wr_en_i) wr_idx <= next_idx(wr_idx);
      if (rd_fire) rd_idx <= next_idx(rd_idx);
      if (wr_en_i && !rd_fire)
        occ <= occ + OCC_W'(1);
      else if (!wr_en_i && rd_fire)
        occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_en_i) mem[wr_idx] <= wr_data_i;
  end

  // The upstream credit scheme guarantees a free slot for every capture
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_en_i) assert (occ != FULL_OCC);
  end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_stream_reader : drains a fixed-latency FIFO read port into a stream
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 fifo_empty_i,
  output logic                                 fifo_pop_o,
  input  logic [DATA_WIDTH-1:0]                fifo_data_i,
  output logic [DATA_WIDTH-1:0]                m_tdata_o,
  output logic                                 m_tvalid_o,
  input  logic                                 m_tready_i,
  output logic [$clog2(READ_LATENCY+3)-1:0]    buf_level_o
);

  localparam int BUF_DEPTH = skid_depth(READ_LATENCY);
  localparam int LVL_W     = $clog2(BUF_DEPTH+1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("fifo_stream_reader: READ_LATENCY out of range");
    end
  endgenerate

  logic [READ_LATENCY-1:0] tag_q;
  logic [LVL_W-1:0]        inflight;
  logic [LVL_W-1:0]        occ;
  logic [LVL_W:0]          committed;
  logic                    capture;

  assign capture   = tag_q[READ_LATENCY-1];
  assign committed = {1'b0, occ} + {1'b0, inflight};

  // Credit only from registered state so ready never reaches the FIFO pop
  assign fifo_pop_o = rst_n_i & ~fifo_empty_i & (committed < (LVL_W+1)'(BUF_DEPTH));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tag_q    <= '0;
      inflight <= '0;
    end else begin
      tag_q[0] <= fifo_pop_o;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (fifo_pop_o && !capture)
        inflight <= inflight + LVL_W'(1);
      else if (!fifo_pop_o && capture)
        inflight <= inflight - LVL_W'(1);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (capture),
    .wr_data_i  (fifo_data_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .occ_o      (occ)
  );

  assign buf_level_o = occ;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader : scoreboard bench for READ_LATENCY 1 and 3 instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          ready1 = 1'b0, ready3 = 1'b0;
  logic          hold1 = 1'b0, hold3 = 1'b0;
  logic          drop1 = 1'b0, drop3 = 1'b0;
  logic          empty1, empty3, pop1, pop3;
  logic [DW-1:0] fdata1, fdata3, s0, s1;
  logic [DW-1:0] tdata1, tdata3;
  logic          tvalid1, tvalid3;
  logic [1:0]    level1;
  logic [2:0]    level3;

  logic [DW-1:0] fm1 [4096];
  logic [DW-1:0] fm3 [4096];
  int            wp1 = 0, rp1 = 0, wp3 = 0, rp3 = 0;
  logic [DW-1:0] exp1 [$];
  logic [DW-1:0] exp3 [$];

  int checks = 0, errors = 0, cyc = 0;
  int pops1, pops3, xf1, xf3, fp1, fp3, lp1, fx1, fx3, lx1, lx3;
  logic          stall1 = 1'b0, stall3 = 1'b0;
  logic [DW-1:0] held1, held3;

  fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(empty1), .fifo_pop_o(pop1),
    .fifo_data_i(fdata1), .m_tdata_o(tdata1), .m_tvalid_o(tvalid1),
    .m_tready_i(ready1), .buf_level_o(level1)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(empty3), .fifo_pop_o(pop3),
    .fifo_data_i(fdata3), .m_tdata_o(tdata3), .m_tvalid_o(tvalid3),
    .m_tready_i(ready3), .buf_level_o(level3)
  );

  // FIFO read-port models: data registered on pop, plus extra stages for latency 3
  assign empty1 = hold1 | (rp1 == wp1);
  assign empty3 = hold3 | (rp3 == wp3);

  always @(posedge clk) begin
    if (drop1) rp1 <= wp1;
    else if (pop1) rp1 <= rp1 + 1;
    fdata1 <= pop1 ? fm1[rp1[11:0]] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (drop3) rp3 <= wp3;
    else if (pop3) rp3 <= rp3 + 1;
    s0     <= pop3 ? fm3[rp3[11:0]] : 32'hDEAD_BEEF;
    s1     <= s0;
    fdata3 <= s1;
  end

  task automatic push1(input logic [DW-1:0] v);
    fm1[wp1[11:0]] = v;
    wp1++;
    exp1.push_back(v);
  endtask

  task automatic push3(input logic [DW-1:0] v);
    fm3[wp3[11:0]] = v;
    wp3++;
    exp3.push_back(v);
  endtask

  task automatic clear_stats();
    pops1 = 0; pops3 = 0; xf1 = 0; xf3 = 0;
    fp1 = -1; fp3 = -1; lp1 = -1; fx1 = -1; fx3 = -1; lx1 = -1; lx3 = -1;
  endtask

  // One clock: scoreboard and protocol monitors at the falling edge, then step past the rising edge
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (pop1) begin pops1++; if (fp1 < 0) fp1 = cyc; lp1 = cyc; end
      if (pop3) begin pops3++; if (fp3 < 0) fp3 = cyc; end
      checks++;
      if ((pop1 && empty1) || (pop3 && empty3)) begin
        errors++;
        $display("FAIL pop_while_empty: pop1=%b empty1=%b pop3=%b empty3=%b, required no pop while empty",
                 pop1, empty1, pop3, empty3);
      end
      if (stall1) begin
        checks++;
        if (tvalid1 !== 1'b1 || tdata1 !== held1) begin
          errors++;
          $display("FAIL stall_stable1: valid=%b data=%h, required valid=1 data=%h", tvalid1, tdata1, held1);
        end
      end
      if (stall3) begin
        checks++;
        if (tvalid3 !== 1'b1 || tdata3 !== held3) begin
          errors++;
          $display("FAIL stall_stable3: valid=%b data=%h, required valid=1 data=%h", tvalid3, tdata3, held3);
        end
      end
      if (tvalid1 && ready1) begin
        xf1++; if (fx1 < 0) fx1 = cyc; lx1 = cyc;
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL sb1_extra: got %h, required no transfer", tdata1);
        end else begin
          e = exp1.pop_front();
          if (tdata1 !== e) begin
            errors++;
            $display("FAIL sb1_data: got %h, required %h", tdata1, e);
          end
        end
      end
      if (tvalid3 && ready3) begin
        xf3++; if (fx3 < 0) fx3 = cyc; lx3 = cyc;
        checks++;
        if (exp3.size() == 0) begin
          errors++;
          $display("FAIL sb3_extra: got %h, required no transfer", tdata3);
        end else begin
          e = exp3.pop_front();
          if (tdata3 !== e) begin
            errors++;
            $display("FAIL sb3_data: got %h, required %h", tdata3, e);
          end
        end
      end
    end
    stall1 = rst_n && tvalid1 && !ready1; held1 = tdata1;
    stall3 = rst_n && tvalid3 && !ready3; held3 = tdata3;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin push1(32'(i)); push3(32'(i)); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (pop1 !== 1'b0 || pop3 !== 1'b0) begin
        errors++; $display("FAIL reset_pop: pop1=%b pop3=%b, required 0 0", pop1, pop3);
      end
      checks++;
      if (tvalid1 !== 1'b0 || tvalid3 !== 1'b0) begin
        errors++; $display("FAIL reset_valid: v1=%b v3=%b, required 0 0", tvalid1, tvalid3);
      end
      checks++;
      if (level1 !== 2'd0 || level3 !== 3'd0) begin
        errors++; $display("FAIL reset_level: l1=%0d l3=%0d, required 0 0", level1, level3);
      end
      checks++;
      if (tdata1 !== '0 || tdata3 !== '0) begin
        errors++; $display("FAIL reset_data: d1=%h d3=%h, required 0 0", tdata1, tdata3);
      end
    end
    drop1 = 1'b1; drop3 = 1'b1;
    cycle();
    drop1 = 1'b0; drop3 = 1'b0;
    exp1.delete(); exp3.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    clear_stats();
    ready1 = 1'b1;
    for (int i = 0; i < 16; i++) push1(32'(i));
    for (int c = 0; c < 40; c++) cycle();
    checks++;
    if (pops1 != 16 || lp1 - fp1 != 15) begin
      errors++; $display("FAIL stream_pops: pops=%0d span=%0d, required 16 15", pops1, lp1 - fp1);
    end
    checks++;
    if (fx1 != fp1 + 2) begin
      errors++; $display("FAIL stream_latency: first valid %0d cycles after pop, required 2", fx1 - fp1);
    end
    checks++;
    if (xf1 != 16 || lx1 - fx1 != 15 || exp1.size() != 0) begin
      errors++; $display("FAIL stream_xfers: count=%0d span=%0d left=%0d, required 16 15 0",
                         xf1, lx1 - fx1, exp1.size());
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    ready3 = 1'b0;
    for (int i = 0; i < 20; i++) push3(32'h100 + 32'(i));
    for (int c = 0; c < 15; c++) cycle();
    checks++;
    if (pops3 != 5) begin
      errors++; $display("FAIL bp_pops: got %0d pops, required 5", pops3);
    end
    checks++;
    if (level3 !== 3'd5) begin
      errors++; $display("FAIL bp_level: got %0d, required 5", level3);
    end
    checks++;
    if (tvalid3 !== 1'b1 || tdata3 !== 32'h100) begin
      errors++; $display("FAIL bp_head: valid=%b data=%h, required 1 00000100", tvalid3, tdata3);
    end
    fp3 = -1;
    ready3 = 1'b1;
    for (int c = 0; c < 80 && exp3.size() != 0; c++) cycle();
    checks++;
    if (exp3.size() != 0 || xf3 != 20) begin
      errors++; $display("FAIL bp_drain: delivered %0d, left %0d, required 20 0", xf3, exp3.size());
    end
    checks++;
    if (lx3 - fx3 != 19) begin
      errors++; $display("FAIL bp_gapless: span=%0d, required 19", lx3 - fx3);
    end
    checks++;
    if (fp3 != fx3 + 1) begin
      errors++; $display("FAIL bp_repop: pop resumed %0d cycles after first transfer, required 1", fp3 - fx3);
    end
  endtask

  task automatic test_intermittent();
    int n1 = 0, n3 = 0;
    clear_stats();
    for (int c = 0; c < 20000 && (n1 < 1000 || n3 < 1000 || exp1.size() != 0 || exp3.size() != 0); c++) begin
      ready1 = 1'($urandom_range(0, 1));
      ready3 = 1'($urandom_range(0, 1));
      hold1  = ($urandom_range(0, 3) == 0);
      hold3  = ($urandom_range(0, 3) == 0);
      if (n1 < 1000 && $urandom_range(0, 2) != 0) begin push1($urandom); n1++; end
      if (n3 < 1000 && $urandom_range(0, 2) != 0) begin push3($urandom); n3++; end
      cycle();
    end
    hold1 = 1'b0; hold3 = 1'b0; ready1 = 1'b1; ready3 = 1'b1;
    checks++;
    if (xf1 != 1000 || exp1.size() != 0) begin
      errors++; $display("FAIL rand_lossless1: delivered %0d left %0d, required 1000 0", xf1, exp1.size());
    end
    checks++;
    if (xf3 != 1000 || exp3.size() != 0) begin
      errors++; $display("FAIL rand_lossless3: delivered %0d left %0d, required 1000 0", xf3, exp3.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    ready3 = 1'b0;
    for (int i = 0; i < 10; i++) push3(32'h200 + 32'(i));
    for (int c = 0; c < 20 && level3 != 3'd3; c++) cycle();
    checks++;
    if (level3 !== 3'd3 || pops3 != 5) begin
      errors++; $display("FAIL mid_setup: level=%0d pops=%0d, required 3 5", level3, pops3);
    end
    rst_n = 1'b0; drop3 = 1'b1;
    exp3.delete();
    cycle();
    drop3 = 1'b0;
    checks++;
    if (tvalid3 !== 1'b0 || level3 !== 3'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b level=%0d, required 0 0", tvalid3, level3);
    end
    rst_n = 1'b1; ready3 = 1'b1;
    for (int c = 0; c < 15; c++) cycle();
    checks++;
    if (xf3 != 0) begin
      errors++; $display("FAIL mid_stale: %0d stale transfers, required 0", xf3);
    end
    for (int i = 0; i < 3; i++) push3(32'h300 + 32'(i));
    for (int c = 0; c < 15; c++) cycle();
    checks++;
    if (xf3 != 3 || exp3.size() != 0) begin
      errors++; $display("FAIL mid_resume: delivered %0d left %0d, required 3 0", xf3, exp3.size());
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_streaming();
    test_backpressure();
    test_intermittent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
